left_shift_register: RTL and testbench

LEFT_SHIFT_REGISTER -- requirements
Module: left_shift_register

---
 rtl/left_shift_register.sv | 62 ++++++
 tb/tb_left_shift_register.sv | 138 +++++++++++++
 2 files changed

// File: rtl/left_shift_register.sv
// left_shift_register: parallel-load, shift-left register with serial output.
// Per-edge priority: synchronous active-low reset, then load, then shift, then hold.
// Optional build macro LEFT_SHIFT_REGISTER_ROTATE_EN turns the shift into a
// rotate-left (the fill bit is q[WIDTH-1]). Without it the fill bit is 0.
// Ports are the same in both builds.
module left_shift_register #(
    parameter int WIDTH = 4   // register width in bits, must be at least 2
) (
    input  logic             clk,
    input  logic             rst,        // synchronous, active-low
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    output logic [WIDTH-1:0] q,
    output logic             serial_out
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shifted;
    logic             fill;

`ifdef LEFT_SHIFT_REGISTER_ROTATE_EN
    // Rotate: the bit leaving the top comes back in at bit 0.
    assign fill = q_reg[WIDTH-1];
`else
    // Plain shift: zeros enter at bit 0, and the top bit is discarded.
    assign fill = 1'b0;
`endif

    // Build the shifted vector bit by bit. Bit 0 takes the fill bit, and every
    // other bit takes the value of its lower neighbour.
    assign shifted[0] = fill;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shifted[gi] = q_reg[gi-1];
        end
    endgenerate

    // Next-state selection. Load has priority over shift. With neither, q holds.
    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = d;
        end else if (shift_en) begin
            q_next = shifted;
        end
    end

    // State register. Reset is sampled only on the rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q          = q_reg;
    assign serial_out = q_reg[WIDTH-1];

endmodule

// File: tb/tb_left_shift_register.sv
// tb_left_shift_register: directed plus random stimulus. A scoreboard queue holds
// the expected values. Each step drives its inputs on the falling edge and pushes
// the expected q. After the rising edge the step pops that entry and compares it
// with the DUT outputs.
module tb_left_shift_register;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             shift_en;
    logic [WIDTH-1:0] q;
    logic             serial_out;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q;       // the bench's own copy of the register value
    logic [WIDTH-1:0] exp_queue[$];  // expected q after each driven edge

    left_shift_register #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .d          (d),
        .shift_en   (shift_en),
        .q          (q),
        .serial_out (serial_out)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour for one rising edge, given the inputs in force.
    function automatic logic [WIDTH-1:0] ref_next(input logic [WIDTH-1:0] cur,
                                                  input logic r, input logic l,
                                                  input logic [WIDTH-1:0] dd,
                                                  input logic s);
        logic f;
`ifdef LEFT_SHIFT_REGISTER_ROTATE_EN
        f = cur[WIDTH-1];
`else
        f = 1'b0;
`endif
        if (!r)     return '0;
        else if (l) return dd;
        else if (s) return {cur[WIDTH-2:0], f};
        else        return cur;
    endfunction

    // Compare q and serial_out with an expected register value.
    task automatic check_q(input string tag, input logic [WIDTH-1:0] exp);
        checks++;
        assert (q === exp) else begin
            errors++;
            $error("FAIL %s q: got %b expected %b", tag, q, exp);
        end
        checks++;
        assert (serial_out === exp[WIDTH-1]) else begin
            errors++;
            $error("FAIL %s serial_out: got %b expected %b", tag, serial_out, exp[WIDTH-1]);
        end
    endtask

    // Run one clocked transaction. Inputs change on the falling edge. The
    // expected value is pushed at that point, and it is popped and compared
    // 1 ns after the rising edge.
    task automatic step(input string tag, input logic r, input logic l,
                        input logic [WIDTH-1:0] dd, input logic s);
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        rst = r; load = l; d = dd; shift_en = s;
        model_q = ref_next(model_q, r, l, dd, s);
        exp_queue.push_back(model_q);
        @(posedge clk);
        #1;
        exp = exp_queue.pop_front();
        $display("step %-10s rst=%b load=%b d=%b shift_en=%b -> q=%b serial_out=%b (exp %b)",
                 tag, r, l, dd, s, q, serial_out, exp);
        check_q(tag, exp);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; d = '0; shift_en = 1'b0;
        model_q = 'x;

        // Reset wins over load.
        step("reset", 1'b0, 1'b1, 4'b1111, 1'b0);

        // Load wins over shift.
        step("load_pri", 1'b1, 1'b1, 4'b1101, 1'b1);

        // Five shifts from 1101. With a plain shift the register drains to zero and
        // stays there. With rotate the pattern cycles.
        for (int i = 0; i < 5; i++) step("shift", 1'b1, 1'b0, 4'b0000, 1'b1);

        // Hold 1010 for three edges.
        step("load_1010", 1'b1, 1'b1, 4'b1010, 1'b0);
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 4'b0000, 1'b0);

        // Reset driven low between edges must not change q until the next edge.
        @(negedge clk);
        rst = 1'b0;
        #2;
        $display("step %-10s rst=0 between edges -> q=%b serial_out=%b (exp %b)",
                 "async_chk", q, serial_out, model_q);
        check_q("async_chk", model_q);
        step("sync_rst", 1'b0, 1'b0, 4'b0000, 1'b0);

        // Reset in the middle of a shift, then hold, then resume shifting.
        step("load_0111", 1'b1, 1'b1, 4'b0111, 1'b0);
        step("shift_a", 1'b1, 1'b0, 4'b0000, 1'b1);
        step("rst_mid", 1'b0, 1'b0, 4'b0000, 1'b1);
        step("hold_zero", 1'b1, 1'b0, 4'b0000, 1'b0);
        step("load_1001", 1'b1, 1'b1, 4'b1001, 1'b0);
        step("shift_b", 1'b1, 1'b0, 4'b0000, 1'b1);

        // Random mix of controls. Reset is kept rare so that the other rows get exercised.
        for (int i = 0; i < 40; i++) begin
            step("random", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                 4'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Backstop so the run always ends, even if the clock stops.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
